// File: rtl/uc_secuenciador.sv
// Control unit for the single-cycle 8-bit microcontroller: opcode decode plus
// I/O handshake stalls with timeout, HALT state and single-step debug gating.
module uc_secuenciador #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       io_ack,
    input  logic       dbg_mode,
    input  logic       dbg_step,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we3,
    output logic       s_mem_rd2,
    output logic       s_e,
    output logic       s_s,
    output logic [2:0] op,
    output logic       pc_en,
    output logic       io_req,
    output logic       io_err,
    output logic       halted
);

    typedef enum logic [1:0] {RUN, IO_WAIT, HALT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               io_err_q, io_err_d;
    logic               dbg_step_q;
    logic               timeout_now;

    logic is_alu, is_loadi, is_jmp, is_jz, is_jnz, is_in, is_out, is_outi, is_halt, is_io;
    logic go;

    assign is_alu   = opcode[3];
    assign is_loadi = (opcode[3:0] == 4'b0000);
    assign is_jmp   = (opcode[3:0] == 4'b0001);
    assign is_jz    = (opcode[3:0] == 4'b0010);
    assign is_jnz   = (opcode[3:0] == 4'b0011);
    assign is_in    = (opcode[3:0] == 4'b0100);
    assign is_out   = (opcode[3:0] == 4'b0101);
    assign is_outi  = (opcode[3:0] == 4'b0110);
    assign is_halt  = (opcode == 6'b110111);
    assign is_io    = is_in | is_out | is_outi;

    // A step request counts once per rising edge of the level input.
    assign go = ~dbg_mode | (dbg_step & ~dbg_step_q);

    always_comb begin
        s_inc       = 1'b1;
        s_inm       = 1'b0;
        we3         = 1'b0;
        s_mem_rd2   = 1'b0;
        s_e         = 1'b0;
        s_s         = 1'b0;
        op          = 3'b000;
        pc_en       = 1'b0;
        io_req      = 1'b0;
        halted      = 1'b0;
        timeout_now = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        io_err_d    = io_err_q;

        if (reset) begin
            if (state_q != HALT) begin
                // Mux selects follow the decode; only the strobes are sequenced.
                if (is_jmp)      s_inc = 1'b0;
                else if (is_jz)  s_inc = ~zero;
                else if (is_jnz) s_inc = zero;
                s_inm     = is_loadi;
                s_e       = is_in;
                s_mem_rd2 = is_outi;
                if (is_alu) op = opcode[2:0];
            end

            case (state_q)
                RUN: begin
                    if (go) begin
                        if (is_halt) begin
                            state_d = HALT;
                        end else if (is_io) begin
                            io_req = 1'b1;
                            if (io_ack) begin
                                we3   = is_in;
                                s_s   = is_out | is_outi;
                                pc_en = 1'b1;
                            end else begin
                                state_d = IO_WAIT;
                                cnt_d   = '0;
                            end
                        end else begin
                            we3   = is_alu | is_loadi;
                            pc_en = 1'b1;
                        end
                    end
                end
                IO_WAIT: begin
                    io_req = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (io_ack) begin
                        we3     = is_in;
                        s_s     = is_out | is_outi;
                        pc_en   = 1'b1;
                        state_d = RUN;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Outputs still latch their data on timeout; a read is dropped.
                        timeout_now = 1'b1;
                        io_err_d    = 1'b1;
                        s_s         = is_out | is_outi;
                        pc_en       = 1'b1;
                        state_d     = RUN;
                    end
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end

        io_err = io_err_q | timeout_now;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            io_err_q   <= 1'b0;
            dbg_step_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            io_err_q   <= io_err_d;
            dbg_step_q <= dbg_step;
        end
    end

endmodule

// File: tb/tb_uc_secuenciador.sv
// Table-driven plus hand-sequenced bench for uc_secuenciador with a scoreboard queue.
module tb_uc_secuenciador;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero, io_ack, dbg_mode, dbg_step;
    logic       s_inc, s_inm, we3, s_mem_rd2, s_e, s_s;
    logic [2:0] op;
    logic       pc_en, io_req, io_err, halted;

    int checks = 0;
    int errors = 0;

    uc_secuenciador #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .io_ack(io_ack),
        .dbg_mode(dbg_mode), .dbg_step(dbg_step),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .s_mem_rd2(s_mem_rd2), .s_e(s_e),
        .s_s(s_s), .op(op), .pc_en(pc_en), .io_req(io_req), .io_err(io_err),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Bit layout: inc inm we3 mrd2 s_e s_s op[2:0] pc_en io_req io_err halted
    localparam logic [12:0] FULL  = 13'h1FFF;
    localparam logic [12:0] STALL = 13'h048C;
    localparam logic [12:0] IOM   = 13'h048F;

    typedef struct {
        logic        rn;
        logic [5:0]  opc;
        logic        z, ack, dm, ds;
        logic [12:0] exp;
        logic [12:0] mask;
        string       name;
    } vec_t;

    typedef struct {
        logic [12:0] exp;
        logic [12:0] mask;
        string       name;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[$];

    function automatic logic [12:0] ev(input bit inc, inm, we, mrd, se, ss,
                                       input bit [2:0] o,
                                       input bit pc, req, err, hlt);
        return {inc, inm, we, mrd, se, ss, o, pc, req, err, hlt};
    endfunction

    localparam logic [12:0] RST_V = 13'h1000;

    task automatic apply(input logic rn, input logic [5:0] opc,
                         input logic z, ack, dm, ds,
                         input logic [12:0] e, m, input string nm);
        sb_t         s;
        logic [12:0] got;
        reset = rn; opcode = opc; zero = z; io_ack = ack; dbg_mode = dm; dbg_step = ds;
        sb.push_back('{exp: e, mask: m, name: nm});
        @(negedge clk);
        got = {s_inc, s_inm, we3, s_mem_rd2, s_e, s_s, op, pc_en, io_req, io_err, halted};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty got=%b", nm, got);
        end else begin
            s = sb.pop_front();
            if ((got & s.mask) !== (s.exp & s.mask)) begin
                errors++;
                $display("FAIL %s got=%b expected=%b mask=%b", s.name, got, s.exp, s.mask);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; opcode = 6'h0A; zero = 1'b0; io_ack = 1'b1;
        dbg_mode = 1'b0; dbg_step = 1'b0;

        tbl.push_back('{1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, ev(1,1,1,0,0,0,3'b000,1,0,0,0), FULL, "loadi"});
        tbl.push_back('{1'b1, 6'h0A, 1'b0, 1'b0, 1'b0, 1'b0, ev(1,0,1,0,0,0,3'b010,1,0,0,0), FULL, "alu_a"});
        tbl.push_back('{1'b1, 6'h01, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,3'b000,1,0,0,0), FULL, "jmp"});
        tbl.push_back('{1'b1, 6'h02, 1'b1, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,3'b000,1,0,0,0), FULL, "jz_z1"});
        tbl.push_back('{1'b1, 6'h02, 1'b0, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,0,0,3'b000,1,0,0,0), FULL, "jz_z0"});
        tbl.push_back('{1'b1, 6'h03, 1'b1, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,0,0,3'b000,1,0,0,0), FULL, "jnz_z1"});
        tbl.push_back('{1'b1, 6'h03, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,3'b000,1,0,0,0), FULL, "jnz_z0"});
        tbl.push_back('{1'b1, 6'h07, 1'b0, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,0,0,3'b000,1,0,0,0), FULL, "nop07"});
        tbl.push_back('{1'b1, 6'h27, 1'b0, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,0,0,3'b000,1,0,0,0), FULL, "nop27"});
        tbl.push_back('{1'b1, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, ev(1,0,1,0,0,0,3'b111,1,0,0,0), FULL, "alu_3f"});
        tbl.push_back('{1'b1, 6'h04, 1'b0, 1'b1, 1'b0, 1'b0, ev(1,0,1,0,1,0,3'b000,1,1,0,0), FULL, "in_zw"});
        tbl.push_back('{1'b1, 6'h05, 1'b0, 1'b1, 1'b0, 1'b0, ev(1,0,0,0,0,1,3'b000,1,1,0,0), FULL, "out_zw"});
        tbl.push_back('{1'b1, 6'h06, 1'b0, 1'b1, 1'b0, 1'b0, ev(1,0,0,1,0,1,3'b000,1,1,0,0), FULL, "outi_zw"});
        tbl.push_back('{1'b1, 6'h09, 1'b0, 1'b0, 1'b1, 1'b1, ev(1,0,1,0,0,0,3'b001,1,0,0,0), FULL, "dbg_step1"});
        for (int k = 0; k < 4; k++)
            tbl.push_back('{1'b1, 6'h09, 1'b0, 1'b0, 1'b1, 1'b1, ev(0,0,0,0,0,0,3'b000,0,0,0,0), STALL, "dbg_hold"});
        tbl.push_back('{1'b1, 6'h09, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,0,3'b000,0,0,0,0), STALL, "dbg_low"});
        tbl.push_back('{1'b1, 6'h01, 1'b0, 1'b0, 1'b1, 1'b1, ev(0,0,0,0,0,0,3'b000,1,0,0,0), FULL, "dbg_step2"});
        tbl.push_back('{1'b1, 6'h05, 1'b0, 1'b0, 1'b1, 1'b1, ev(0,0,0,0,0,0,3'b000,0,0,0,0), STALL, "dbg_io_gated"});

        @(posedge clk); #1;
        apply(1'b0, 6'h0A, 1'b0, 1'b1, 1'b0, 1'b0, RST_V, FULL, "in_reset_a");
        apply(1'b0, 6'h05, 1'b1, 1'b1, 1'b0, 1'b0, RST_V, FULL, "in_reset_b");

        foreach (tbl[i])
            apply(tbl[i].rn, tbl[i].opc, tbl[i].z, tbl[i].ack, tbl[i].dm, tbl[i].ds,
                  tbl[i].exp, tbl[i].mask, tbl[i].name);

        // IN with ack three cycles after entry
        for (int k = 0; k < 3; k++)
            apply(1'b1, 6'h04, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,3'b000,0,1,0,0), IOM, "in_wait");
        apply(1'b1, 6'h04, 1'b0, 1'b1, 1'b0, 1'b0, ev(1,0,1,0,1,0,3'b000,1,1,0,0), FULL, "in_ack");
        apply(1'b1, 6'h07, 1'b0, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,0,0,3'b000,1,0,0,0), FULL, "after_in");

        // OUT timeout
        for (int k = 0; k < 16; k++)
            apply(1'b1, 6'h05, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,3'b000,0,1,0,0), IOM, "out_wait");
        apply(1'b1, 6'h05, 1'b0, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,0,1,3'b000,1,1,1,0), FULL, "out_timeout");
        apply(1'b1, 6'h07, 1'b0, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,0,0,3'b000,1,0,1,0), FULL, "err_sticky");

        // IN timeout: read dropped
        for (int k = 0; k < 16; k++)
            apply(1'b1, 6'h04, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,3'b000,0,1,1,0), IOM, "in_to_wait");
        apply(1'b1, 6'h04, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,3'b000,1,1,1,0), IOM, "in_timeout");

        // HALT
        apply(1'b1, 6'h37, 1'b0, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,0,0,3'b000,0,0,1,0), FULL, "halt_enter");
        for (int k = 0; k < 6; k++)
            apply(1'b1, 6'h0A, 1'b0, 1'(k % 2), 1'(k / 3), 1'(k % 2),
                  ev(1,0,0,0,0,0,3'b000,0,0,1,1), FULL, "halted");
        apply(1'b0, 6'h0A, 1'b0, 1'b0, 1'b0, 1'b0, RST_V, FULL, "halt_reset");
        apply(1'b1, 6'h07, 1'b0, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,0,0,3'b000,1,0,0,0), FULL, "post_reset");

        // ack coinciding with timeout
        for (int k = 0; k < 16; k++)
            apply(1'b1, 6'h06, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,3'b000,0,1,0,0), IOM, "outi_wait");
        apply(1'b1, 6'h06, 1'b0, 1'b1, 1'b0, 1'b0, ev(1,0,0,1,0,1,3'b000,1,1,0,0), FULL, "ack_at_timeout");

        // reset in the middle of a transfer
        for (int k = 0; k < 3; k++)
            apply(1'b1, 6'h05, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,3'b000,0,1,0,0), IOM, "abort_wait");
        apply(1'b0, 6'h05, 1'b0, 1'b1, 1'b0, 1'b0, RST_V, FULL, "abort_reset");
        apply(1'b1, 6'h07, 1'b0, 1'b0, 1'b0, 1'b0, ev(1,0,0,0,0,0,3'b000,1,0,0,0), FULL, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
